// File: rtl/pyf_imem_wb_bridge_pkg.sv
// Shared encodings for the IMEM-to-Wishbone bridge: SCR1 memory interface
// command/response codes and the bridge FSM state type.
package pyf_imem_wb_bridge_pkg;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } type_pyf_wbb_fsm_e;

   localparam logic [3:0] PYF_WBB_SEL_ALL = 4'hF;

   // Requests the bridge refuses without touching the bus: writes into
   // instruction memory and addresses that are not word aligned.
   function automatic logic is_bad_req(input logic cmd, input logic [1:0] lsb);
      return (cmd == SCR1_MEM_CMD_WR) || (lsb != 2'b00);
   endfunction

endpackage

// File: rtl/pyf_imem_wb_bridge_if.sv
// IMEM request/response port plus Wishbone classic master port of the bridge.
//
// Handshake: the requester holds imem_req with a stable imem_cmd/imem_addr;
// the request is taken on a rising edge where imem_req & imem_req_ack.
// imem_resp is NOTRDY except for exactly one cycle per taken request, and
// imem_rdata is meaningful only in a RDY_OK cycle. On the Wishbone side
// cyc/stb stay high with a stable address until the slave answers with
// wb_ack_i or wb_err_i (or the bridge gives up on a timeout).
//
// modport slave  : the bridge (IMEM slave, Wishbone initiator)
// modport master : the surroundings (IMEM requester and Wishbone target)
interface pyf_imem_wb_bridge_if #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
);
   logic              imem_req_ack;
   logic              imem_req;
   logic              imem_cmd;
   logic [AWIDTH-1:0] imem_addr;
   logic [DWIDTH-1:0] imem_rdata;
   logic [1:0]        imem_resp;

   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [3:0]        wb_sel_o;
   logic [AWIDTH-1:0] wb_adr_o;
   logic [DWIDTH-1:0] wb_dat_i;
   logic              wb_ack_i;
   logic              wb_err_i;

   modport slave (
      input  imem_req, imem_cmd, imem_addr,
      output imem_req_ack, imem_rdata, imem_resp,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
      input  wb_dat_i, wb_ack_i, wb_err_i
   );

   modport master (
      output imem_req, imem_cmd, imem_addr,
      input  imem_req_ack, imem_rdata, imem_resp,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o,
      output wb_dat_i, wb_ack_i, wb_err_i
   );

endinterface

// File: rtl/pyf_imem_wb_bridge.sv
// IMEM slave that turns each SCR1 instruction fetch into one Wishbone
// classic read. One fetch in flight; a new request can be taken in the
// response cycle of the previous one. DWIDTH must be 32 and
// 2**TMO_W must exceed TIMEOUT_CYCLES.
module pyf_imem_wb_bridge
   import pyf_imem_wb_bridge_pkg::*;
#(
   parameter int AWIDTH         = 32,
   parameter int DWIDTH         = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMO_W          = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pyf_imem_wb_bridge_if.slave  bus,
   output type_pyf_wbb_fsm_e    dbg_state
);

   localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   type_pyf_wbb_fsm_e   state, state_nxt;
   logic                cyc, cyc_nxt;
   logic [AWIDTH-1:0]   adr, adr_nxt;
   logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
   type_scr1_mem_resp_e resp, resp_nxt;
   logic [DWIDTH-1:0]   rdata, rdata_nxt;

   logic req_ack;
   logic accept;
   logic tmo_hit;

   // Only the bus phase blocks new requests; IDLE and RESP both accept.
   assign req_ack = (state != BUS);
   assign accept  = bus.imem_req & req_ack;
   // Last allowed stb cycle without an answer; never fires when disabled.
   assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

   // State register and all registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cyc     <= 1'b0;
         adr     <= '0;
         tmo_cnt <= '0;
         resp    <= SCR1_MEM_RESP_NOTRDY;
         rdata   <= '0;
      end else begin
         state   <= state_nxt;
         cyc     <= cyc_nxt;
         adr     <= adr_nxt;
         tmo_cnt <= tmo_cnt_nxt;
         resp    <= resp_nxt;
         rdata   <= rdata_nxt;
      end
   end

   // Next state: decode requests in IDLE/RESP, wait for ack/err/timeout in BUS.
   always_comb begin
      state_nxt   = state;
      cyc_nxt     = cyc;
      adr_nxt     = adr;
      tmo_cnt_nxt = tmo_cnt;
      resp_nxt    = SCR1_MEM_RESP_NOTRDY;
      rdata_nxt   = '0;
      case (state)
         BUS: begin
            tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
            if (bus.wb_err_i) begin
               // Error wins over a simultaneous ack.
               state_nxt = RESP;
               cyc_nxt   = 1'b0;
               resp_nxt  = SCR1_MEM_RESP_RDY_ER;
            end else if (bus.wb_ack_i) begin
               state_nxt = RESP;
               cyc_nxt   = 1'b0;
               resp_nxt  = SCR1_MEM_RESP_RDY_OK;
               rdata_nxt = bus.wb_dat_i;
            end else if (tmo_hit) begin
               state_nxt = RESP;
               cyc_nxt   = 1'b0;
               resp_nxt  = SCR1_MEM_RESP_RDY_ER;
            end
         end
         default: begin
            // IDLE and RESP share the request decode; RESP lasts one cycle.
            state_nxt = IDLE;
            if (accept) begin
               adr_nxt = {bus.imem_addr[AWIDTH-1:2], 2'b00};
               if (is_bad_req(bus.imem_cmd, bus.imem_addr[1:0])) begin
                  state_nxt = RESP;
                  resp_nxt  = SCR1_MEM_RESP_RDY_ER;
               end else begin
                  state_nxt   = BUS;
                  cyc_nxt     = 1'b1;
                  tmo_cnt_nxt = '0;
               end
            end
         end
      endcase
   end

   assign bus.imem_req_ack = req_ack;
   assign bus.imem_resp    = resp;
   assign bus.imem_rdata   = rdata;
   assign bus.wb_cyc_o     = cyc;
   assign bus.wb_stb_o     = cyc;
   assign bus.wb_we_o      = 1'b0;
   assign bus.wb_sel_o     = PYF_WBB_SEL_ALL;
   assign bus.wb_adr_o     = adr;
   assign dbg_state        = state;

endmodule

// File: tb/tb_pyf_imem_wb_bridge.sv
// Bench for pyf_imem_wb_bridge: directed scenarios plus randomized fetches
// against a transaction-level model of the bridge and a Wishbone memory.
module tb_pyf_imem_wb_bridge;
   import pyf_imem_wb_bridge_pkg::*;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;
   localparam int TW  = 3;

   localparam int M_ACK    = 0;
   localparam int M_ERR    = 1;
   localparam int M_SILENT = 2;
   localparam int M_BOTH   = 3;

   typedef struct {
      logic [1:0]    resp;
      logic [DW-1:0] data;
      logic [AW-1:0] wadr;
      int            lat;
      int            acc;
      int            mode;
      int            waits;
   } txn_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   pyf_imem_wb_bridge_if #(.AWIDTH(AW), .DWIDTH(DW)) bus_if ();
   type_pyf_wbb_fsm_e dbg_state;

   pyf_imem_wb_bridge #(
      .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TMO), .TMO_W(TW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .dbg_state (dbg_state)
   );

   int   errors = 0;
   int   checks = 0;
   int   last_acc = 0;
   txn_t exp_q[$];
   txn_t mon_e;

   logic slv_ack = 1'b0;
   logic slv_err = 1'b0;
   logic force_ack = 1'b0;
   int   slv_cnt = 0;

   assign bus_if.wb_ack_i = slv_ack | force_ack;
   assign bus_if.wb_err_i = slv_err;

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      if (a == 32'h0001_0040) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Outcome of one fetch: bad requests answer one cycle after acceptance,
   // slave answers after waits+1 stb cycles, and a slave that has not
   // answered within TMO stb cycles yields an error one cycle later.
   function automatic txn_t model(input logic [AW-1:0] a, input logic c,
                                  input int mode, input int waits);
      txn_t t;
      logic [1:0] lsb;
      lsb     = a[1:0];
      t.wadr  = {a[AW-1:2], 2'b00};
      t.mode  = mode;
      t.waits = waits;
      t.acc   = 0;
      t.resp  = SCR1_MEM_RESP_RDY_ER;
      t.data  = '0;
      if (c || lsb != 2'b00) begin
         t.lat = 1;
      end else if (mode == M_SILENT || waits >= TMO) begin
         t.lat = TMO + 1;
      end else begin
         t.lat = waits + 2;
         if (mode == M_ACK) begin
            t.resp = SCR1_MEM_RESP_RDY_OK;
            t.data = mem_word(t.wadr);
         end
      end
      return t;
   endfunction

   // Wishbone memory: answers the in-flight fetch as the scoreboard describes.
   always @(negedge clk) begin
      if (bus_if.wb_cyc_o === 1'b1 && bus_if.wb_stb_o === 1'b1 && exp_q.size() > 0) begin
         if (exp_q[0].mode != M_SILENT && slv_cnt == exp_q[0].waits) begin
            slv_ack = (exp_q[0].mode == M_ACK) || (exp_q[0].mode == M_BOTH);
            slv_err = (exp_q[0].mode == M_ERR) || (exp_q[0].mode == M_BOTH);
            bus_if.wb_dat_i = mem_word(bus_if.wb_adr_o);
         end else begin
            slv_ack = 1'b0;
            slv_err = 1'b0;
            bus_if.wb_dat_i = $urandom();
         end
         slv_cnt++;
      end else begin
         slv_cnt = 0;
         slv_ack = 1'b0;
         slv_err = 1'b0;
         bus_if.wb_dat_i = $urandom();
      end
   end

   // Scoreboard: every response and every strobe cycle is checked.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.imem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: got resp=%b rdata=%h, required no response",
                        bus_if.imem_resp, bus_if.imem_rdata);
            end else begin
               mon_e = exp_q.pop_front();
               if (bus_if.imem_resp !== mon_e.resp || bus_if.imem_rdata !== mon_e.data) begin
                  errors++;
                  $display("FAIL resp_data adr=%h: got resp=%b rdata=%h, required resp=%b rdata=%h",
                           mon_e.wadr, bus_if.imem_resp, bus_if.imem_rdata, mon_e.resp, mon_e.data);
               end
               checks++;
               if ((cyc_cnt - mon_e.acc) != mon_e.lat) begin
                  errors++;
                  $display("FAIL latency adr=%h: got %0d cycles, required %0d",
                           mon_e.wadr, cyc_cnt - mon_e.acc, mon_e.lat);
               end
            end
         end
         if (bus_if.wb_stb_o !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0 || bus_if.wb_cyc_o !== 1'b1 || bus_if.wb_we_o !== 1'b0 ||
                bus_if.wb_sel_o !== 4'hF || bus_if.wb_adr_o !== exp_q[0].wadr) begin
               errors++;
               $display("FAIL bus_req: got cyc=%b stb=%b we=%b sel=%h adr=%h, required cyc=1 we=0 sel=f adr=%h",
                        bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_sel_o,
                        bus_if.wb_adr_o, (exp_q.size() > 0) ? exp_q[0].wadr : 32'hx);
            end
         end
      end
   end

   // ---------------- driver tasks (start and end at posedge+1) ----------------
   task automatic issue(input logic [AW-1:0] a, input logic c, input int mode,
                        input int waits, input bit keep);
      txn_t t;
      bit   acc;
      int   n;
      bus_if.imem_req  = 1'b1;
      bus_if.imem_addr = a;
      bus_if.imem_cmd  = c;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 30) begin
         @(negedge clk);
         if (bus_if.imem_req_ack === 1'b1) begin
            t     = model(a, c, mode, waits);
            t.acc = cyc_cnt;
            exp_q.push_back(t);
            last_acc = cyc_cnt;
            acc = 1'b1;
         end
         n++;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout addr=%h: got no req_ack in 30 cycles, required acceptance", a);
      end
      @(posedge clk);
      #1;
      if (!keep) begin
         bus_if.imem_req  = 1'b0;
         bus_if.imem_addr = $urandom();
         bus_if.imem_cmd  = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0 || bus_if.wb_adr_o !== '0) begin
         errors++;
         $display("FAIL reset_bus: got cyc=%b stb=%b adr=%h, required 0 0 0",
                  bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_adr_o);
      end
      checks++;
      if (bus_if.imem_resp !== 2'b00 || bus_if.imem_rdata !== '0) begin
         errors++;
         $display("FAIL reset_resp: got resp=%b rdata=%h, required 00 0",
                  bus_if.imem_resp, bus_if.imem_rdata);
      end
      checks++;
      if (bus_if.imem_req_ack !== 1'b1 || dbg_state !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got req_ack=%b state=%0d, required 1 IDLE",
                  bus_if.imem_req_ack, dbg_state);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_zero_wait();
      issue(32'h0001_0040, 1'b0, M_ACK, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus_if.wb_stb_o !== 1'b1 || bus_if.wb_adr_o !== 32'h0001_0040) begin
         errors++;
         $display("FAIL zw_stb: got stb=%b adr=%h, required 1 00010040",
                  bus_if.wb_stb_o, bus_if.wb_adr_o);
      end
      @(negedge clk);
      checks++;
      if (bus_if.imem_resp !== 2'b01 || bus_if.imem_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL zw_resp: got resp=%b rdata=%h, required 01 deadbeef",
                  bus_if.imem_resp, bus_if.imem_rdata);
      end
      @(negedge clk);
      checks++;
      if (bus_if.imem_resp !== 2'b00) begin
         errors++;
         $display("FAIL zw_one_cycle: got resp=%b, required 00", bus_if.imem_resp);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int a1;
      issue(32'h0000_0100, 1'b0, M_ACK, 2, 1'b1);
      a1 = last_acc;
      issue(32'h0000_0104, 1'b0, M_ACK, 2, 1'b0);
      checks++;
      if (last_acc - a1 != 4) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d cycles between accepts, required 4", last_acc - a1);
      end
      drain();
   endtask

   task automatic test_errors();
      issue(32'h0000_0200, 1'b1, M_ACK, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.imem_resp !== 2'b10 || bus_if.imem_rdata !== '0) begin
         errors++;
         $display("FAIL err_write: got cyc=%b resp=%b rdata=%h, required 0 10 0",
                  bus_if.wb_cyc_o, bus_if.imem_resp, bus_if.imem_rdata);
      end
      drain();
      issue(32'h0000_0202, 1'b0, M_ACK, 0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus_if.wb_cyc_o !== 1'b0 || bus_if.imem_resp !== 2'b10 || bus_if.imem_rdata !== '0) begin
         errors++;
         $display("FAIL err_misalign: got cyc=%b resp=%b rdata=%h, required 0 10 0",
                  bus_if.wb_cyc_o, bus_if.imem_resp, bus_if.imem_rdata);
      end
      drain();
      issue(32'h0000_0300, 1'b0, M_ERR, 1, 1'b0);
      drain();
      issue(32'h0000_0304, 1'b0, M_BOTH, 0, 1'b0);
      drain();
      issue(32'h0000_0400, 1'b0, M_ACK, TMO - 1, 1'b0);
      drain();
   endtask

   task automatic test_timeout();
      int n;
      int stb_cycles;
      issue(32'h0000_0500, 1'b0, M_SILENT, 0, 1'b0);
      n = 0;
      stb_cycles = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         if (bus_if.wb_stb_o === 1'b1) stb_cycles++;
         n++;
      end
      checks++;
      if (stb_cycles != TMO) begin
         errors++;
         $display("FAIL tmo_stb_cycles: got %0d, required %0d", stb_cycles, TMO);
      end
      drain();
      force_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus_if.imem_resp !== 2'b00 || bus_if.wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL late_ack: got resp=%b cyc=%b, required 00 0",
                     bus_if.imem_resp, bus_if.wb_cyc_o);
         end
      end
      @(posedge clk);
      #1;
      force_ack = 1'b0;
      issue(32'h0000_0504, 1'b0, M_ACK, 1, 1'b0);
      drain();
   endtask

   task automatic test_reset_mid_bus();
      issue(32'h0000_0600, 1'b0, M_SILENT, 0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++;
         if (bus_if.wb_cyc_o !== 1'b0 || bus_if.wb_stb_o !== 1'b0 ||
             bus_if.imem_resp !== 2'b00 || bus_if.imem_rdata !== '0) begin
            errors++;
            $display("FAIL rst_mid_bus: got cyc=%b stb=%b resp=%b rdata=%h, required 0 0 00 0",
                     bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.imem_resp, bus_if.imem_rdata);
         end
      end
      @(posedge clk);
      #1;
      issue(32'h0000_0604, 1'b0, M_ACK, 1, 1'b0);
      drain();
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      logic          c;
      int            r, mode, waits;
      bit            keep;
      for (int i = 0; i < 30; i++) begin
         a = $urandom();
         a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         c = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 9);
         mode  = (r < 6) ? M_ACK : (r < 8) ? M_ERR : (r == 8) ? M_BOTH : M_SILENT;
         waits = $urandom_range(0, 5);
         keep  = ($urandom_range(0, 1) == 1) && (i != 29);
         issue(a, c, mode, waits, keep);
         if (!keep) begin
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      drain();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus_if.imem_req  = 1'b0;
      bus_if.imem_cmd  = 1'b0;
      bus_if.imem_addr = '0;
      bus_if.wb_dat_i  = '0;
      test_reset();
      test_zero_wait();
      test_back_to_back();
      test_errors();
      test_timeout();
      test_reset_mid_bus();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 ns, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pyf_imem_wb_bridge.md
Name: pyf_imem_wb_bridge

Overview:
- Instruction-memory slave that consumes the port1 side of the IMEM router.
- Converts the SCR1 IMEM request/response protocol into single Wishbone classic read cycles toward the Caravel/pyfive bus.
- One transaction outstanding at a time, with back-to-back acceptance in the response cycle.
- Bus errors, bus timeouts, bad commands and misaligned addresses all return SCR1_MEM_RESP_RDY_ER.

Parameters:
- AWIDTH, 32: IMEM and Wishbone address width.
- DWIDTH, 32: data width; must be 32.
- TIMEOUT_CYCLES, 255: maximum number of cycles with stb asserted and no ack/err before an error is forced; 0 disables the timeout.
- TMO_W, 8: timeout counter width; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_ack  out  1  request accepted this cycle.
- imem_req  in  1  request valid.
- imem_cmd  in  1  0 = read; 1 = write (illegal for IMEM).
- imem_addr  in  AWIDTH  byte address.
- imem_rdata  out  DWIDTH  read data; valid only while imem_resp == RDY_OK.
- imem_resp  out  2  00 NOTRDY, 01 RDY_OK, 10 RDY_ER.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  always 0.
- wb_sel_o  out  4  always 4'hF.
- wb_adr_o  out  AWIDTH  word-aligned address ({addr[AWIDTH-1:2],2'b00}).
- wb_dat_i  in  DWIDTH  read data.
- wb_ack_i  in  1  normal termination.
- wb_err_i  in  1  error termination.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n. Every flop resets on a posedge clk with rst_n == 0.
- Reset values:
  - state = IDLE.
  - wb_cyc_o = wb_stb_o = 0; wb_adr_o = 0; timeout counter = 0.
  - imem_resp = NOTRDY; imem_rdata = 0.
- Handshake rules:
  - A request is accepted on a cycle where imem_req & imem_req_ack.
  - imem_req_ack is combinational: 1 in IDLE and in RESP, 0 in BUS.
  - imem_resp is registered and is non-NOTRDY for exactly one cycle per accepted request.
- States:
  - IDLE: on an accepted request, register the address.
    - cmd == 1 or addr[1:0] != 0 → RESP with ER pending; no bus cycle.
    - Otherwise → BUS, with wb_cyc_o = wb_stb_o = 1 from the next cycle.
  - BUS: cyc/stb held high, address stable, counter increments each cycle.
    - wb_ack_i → capture wb_dat_i, → RESP with OK.
    - wb_err_i (or ack & err together; err wins) → RESP with ER.
    - Counter == TIMEOUT_CYCLES-1 with no ack/err, when TIMEOUT_CYCLES != 0 → RESP with ER.
    - cyc/stb drop on the same edge that leaves BUS.
  - RESP: drive imem_resp (OK with rdata, or ER) for this cycle only.
    - New request accepted this cycle → IDLE-style decode, going to BUS or RESP next.
    - Otherwise → IDLE.
- Latency:
  - Read with a zero-wait slave (ack in the first stb cycle): request accept cycle N, stb cycles N+1, ack N+1, imem_resp OK at N+2.
  - Back-to-back throughput is one word per 2 cycles.
- Boundary conditions:
  - wb_ack_i / wb_err_i outside BUS are ignored.
  - imem_rdata is 0 on an ER response.
  - Timeout counter clears on every entry to BUS.
  - Reset asserted during BUS: cyc/stb low after that edge; no response is ever emitted for the aborted request.
  - A late ack from the slave after a timeout is ignored.
  - imem_addr and imem_cmd are sampled only at acceptance; they may change afterwards.

Decomposition:
- Shared package (existing scr1 memif include):
  - SCR1_MEM_RESP_NOTRDY, SCR1_MEM_RESP_RDY_OK and SCR1_MEM_RESP_RDY_ER encodings.
  - SCR1_MEM_CMD_RD and SCR1_MEM_CMD_WR.
- Local enum type_pyf_wbb_fsm_e {IDLE, BUS, RESP}.
- No sub-module: the timeout counter is inline.

Test Plan:
1. Read, zero-wait slave: req addr 0x0001_0040 at cycle 0 → wb_adr_o 0x0001_0040, stb at cycle 1, ack with dat 0xDEAD_BEEF at cycle 1 → imem_resp 01 and rdata 0xDEAD_BEEF at cycle 2 only.
2. Back-to-back: req held with addrs 0x100 then 0x104, slave acks with 2 waits → second request accepted in the RESP cycle of the first; exactly two OK responses, in order.
3. Errors:
   - cmd = 1 at addr 0x200 → no wb_cyc_o; imem_resp 10 one cycle after accept.
   - addr 0x202 → same ER response.
   - wb_err_i during BUS → ER response.
4. Timeout with TIMEOUT_CYCLES = 4, slave never acks → stb high for exactly 4 cycles, then low; imem_resp 10 on the next cycle; a later ack is ignored.
5. Reset mid-BUS: drive rst_n = 0 for one edge while stb is high → cyc/stb 0 and imem_resp 00 after that edge; a subsequent request completes normally.
